ps2_scancode_receiver: RTL and testbench
========================================

PS2_SCANCODE_RECEIVER -- requirements
Module: ps2_scancode_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of scancode entries buffered; power of two, >= 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops on ps2_clk and ps2_data; >= 2.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 10000, clk cycles of frame inactivity before abort.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-007 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-008 SHALL have port code  output  8  scancode byte at FIFO head.
REQ-009 SHALL have port extended  output  1  head entry was preceded by 0xE0.
REQ-010 SHALL have port release  output  1  head entry was preceded by 0xF0 (break code).
REQ-011 SHALL have port valid  output  1  FIFO non-empty; code/extended/release meaningful.
REQ-012 SHALL have port ready  input  1  consumer accepts head entry when valid && ready.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse: frame with bad odd parity discarded.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse: bad stop bit or timeout.
REQ-015 SHALL have port overflow  output  1  one-cycle pulse: entry dropped, FIFO full.
REQ-016 SHALL have port count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Function
REQ-017 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops each; flops reset to 1 (idle bus).
REQ-018 SHALL detect a falling edge as synchronised clock previous=1, current=0; synchronised data sampled that cycle.
REQ-019 SHALL run FSM IDLE, DATA, PARITY, STOP; only falling edges advance it.
REQ-020 IDLE: falling edge with data=0 (start) -> DATA, bit counter=0; data=1 -> stay IDLE, no flag.
REQ-021 DATA: shift sampled bit in LSB first; after 8th bit -> PARITY.
REQ-022 PARITY: record parity_ok = odd number of ones across 8 data bits plus parity bit -> STOP.
REQ-023 STOP: data=1 and parity_ok -> byte accepted; data=1, !parity_ok -> parity_err; data=0 -> frame_err (takes precedence over parity); always -> IDLE.
REQ-024 Timeout: in any state except IDLE, counter clears on each falling edge, increments otherwise; reaching TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial byte discarded.
REQ-025 Accepted 0xE0 SHALL set pending-extended flag; accepted 0xF0 SHALL set pending-release flag; neither pushes.
REQ-026 Any other accepted byte SHALL push {extended, release, byte} from pending flags, then clear both flags.
REQ-027 parity_err or frame_err SHALL clear both pending flags.
REQ-028 Push occurs in cycle after the stop-bit falling edge; valid asserts one cycle after push into empty FIFO.
REQ-029 FIFO SHALL be show-ahead: code/extended/release reflect head whenever valid=1; pop on valid && ready.
REQ-030 Push when full and no pop SHALL drop the new entry, pulse overflow, leave contents unchanged.
REQ-031 Push and pop same cycle SHALL both take effect, including when full (no overflow) and count unchanged.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-033 ready while valid=0 SHALL have no effect.

Reset
REQ-034 rst_n low SHALL asynchronously force: FSM IDLE, counters 0, pending flags 0, FIFO empty, valid=0, count=0, code=0, extended=0, release=0, all error/overflow pulses 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; after release, reception resumes only at next start bit.

Verification
REQ-036 Frame 0x1C, parity 0, stop 1 -> valid, code=0x1C, extended=0, release=0, count=1; ready pops, valid=0.
REQ-037 Frames 0xE0, 0xF0, 0x74 -> exactly one entry: code=0x74, extended=1, release=1; count=1.
REQ-038 Frame 0xAA with parity 0 -> parity_err one cycle, count=0; next 0x1C frame received with extended=0, release=0.
REQ-039 Start + 3 data bits, then ps2_clk idle TIMEOUT_CYCLES -> frame_err one cycle, FSM IDLE; following 0x29 frame received correctly.
REQ-040 FIFO_DEPTH=4, ready=0, five frames 0x15,0x1D,0x24,0x2D,0x2C -> overflow on 5th, count=4; pops return 0x15,0x1D,0x24,0x2D in order.
REQ-041 rst_n low after 4 data bits of a frame, released, then full 0x1C frame -> single entry 0x1C, no error pulses.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deframes
// 11-bit frames on ps2_clk falling edges, folds 0xE0/0xF0 prefixes into
// flags on the following code byte and buffers results in a show-ahead FIFO.
module ps2_scancode_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [7:0]                      code,
  output logic                            extended,
  output logic                            release_flag,
  output logic                            valid,
  input  logic                            ready,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync_r, data_sync_r;
  logic                   clk_prev_r;
  logic                   fall_s, bit_s;

  state_t          state_r, state_s;
  logic [2:0]      bit_cnt_r, bit_cnt_s;
  logic [7:0]      shift_r, shift_s;
  logic            parity_ok_r, parity_ok_s;
  logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s;
  logic            accept_s, perr_s, ferr_s;

  logic            accept_r;
  logic [7:0]      byte_r;
  logic            ext_pend_r, rel_pend_r;
  logic            push_s, pop_s, full_s, write_s;

  logic [9:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;

  assign fall_s       = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
  assign bit_s        = data_sync_r[SYNC_STAGES-1];
  assign valid        = (count_r != {CW{1'b0}});
  assign count        = count_r;
  assign code         = mem_r[rd_ptr_r][7:0];
  assign release_flag = mem_r[rd_ptr_r][8];
  assign extended     = mem_r[rd_ptr_r][9];

  // Synchronisers for the asynchronous PS/2 lines, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      parity_ok_r <= 1'b0;
      tmo_cnt_r   <= {TW{1'b0}};
      accept_r    <= 1'b0;
      byte_r      <= 8'd0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      parity_ok_r <= parity_ok_s;
      tmo_cnt_r   <= tmo_cnt_s;
      accept_r    <= accept_s;
      byte_r      <= shift_r;
      parity_err  <= perr_s;
      frame_err   <= ferr_s;
    end
  end

  // Next-state logic: advances only on ps2_clk falling edges; the inactivity
  // timeout overrides everything and abandons the partial frame.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    parity_ok_s = parity_ok_r;
    tmo_cnt_s   = {TW{1'b0}};
    accept_s    = 1'b0;
    perr_s      = 1'b0;
    ferr_s      = 1'b0;

    if (state_r != ST_IDLE && !fall_s) begin
      tmo_cnt_s = tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_s = {TW{1'b0}};
    end

    case (state_r)
      ST_IDLE: begin
        if (fall_s && !bit_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          shift_s = {bit_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fall_s) begin
          parity_ok_s = ^{shift_r, bit_s};
          state_s     = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fall_s) begin
          state_s = ST_IDLE;
          if (!bit_s) begin
            ferr_s = 1'b1;
          end else if (parity_ok_r) begin
            accept_s = 1'b1;
          end else begin
            perr_s = 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (state_r != ST_IDLE && !fall_s && tmo_cnt_s == TW'(TIMEOUT_CYCLES)) begin
      state_s   = ST_IDLE;
      tmo_cnt_s = {TW{1'b0}};
      ferr_s    = 1'b1;
    end else begin
      ferr_s = ferr_s;
    end
  end

  assign push_s  = accept_r && (byte_r != 8'hE0) && (byte_r != 8'hF0);
  assign pop_s   = valid && ready;
  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign write_s = push_s && (!full_s || pop_s);

  // Prefix flags: armed by 0xE0/0xF0, consumed by the next code, dropped on error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (parity_err || frame_err) begin
      ext_pend_r <= 1'b0;
      rel_pend_r <= 1'b0;
    end else if (accept_r) begin
      if (byte_r == 8'hE0) begin
        ext_pend_r <= 1'b1;
      end else if (byte_r == 8'hF0) begin
        rel_pend_r <= 1'b1;
      end else begin
        ext_pend_r <= 1'b0;
        rel_pend_r <= 1'b0;
      end
    end
  end

  // Show-ahead FIFO; a push into a full FIFO survives only if a pop frees a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      overflow <= 1'b0;
    end else begin
      overflow <= push_s && full_s && !pop_s;
      if (write_s) begin
        mem_r[wr_ptr_r] <= {ext_pend_r, rel_pend_r, byte_r};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: bit-bangs PS/2 frames and checks
// decoded entries, prefix folding, error pulses, timeout and FIFO overflow.
module tb_ps2_scancode_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] code;
  logic       extended, release_flag, valid;
  logic       parity_err, frame_err, overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  int perr_n = 0, ferr_n = 0, ovf_n = 0;

  ps2_scancode_receiver #(.FIFO_DEPTH(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(10000)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .extended(extended), .release_flag(release_flag), .valid(valid),
    .ready(ready), .parity_err(parity_err), .frame_err(frame_err),
    .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // Count pulse cycles of each flag; a clean one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (parity_err) perr_n++;
    if (frame_err)  ferr_n++;
    if (overflow)   ovf_n++;
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic good_par, input logic stop);
    logic par;
    par = good_par ? ~^b : ^b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stop);
    repeat (5) @(posedge clk);
    #1 ps2_data = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200; i++) begin
      if (valid === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL %s valid got %b want 1", name, valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", code); end
    checks++; if ({extended, release_flag} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {extended, release_flag}); end
    checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {parity_err, frame_err, overflow}); end
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b1, 1'b1);
    wait_valid("basic_valid");
    @(negedge clk);
    checks++; if (code !== 8'h1C) begin errors++; $display("FAIL basic_code got %h want 1c", code); end
    checks++; if ({extended, release_flag} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {extended, release_flag}); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL basic_count got %0d want 1", count); end
    pop_one();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_pop_count got %0d want 0", count); end
  endtask

  task automatic test_prefix();
    send_frame(8'hE0, 1'b1, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL prefix_nopush got %0d want 0", count); end
    send_frame(8'h74, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL prefix_count got %0d want 1", count); end
    checks++; if (code !== 8'h74) begin errors++; $display("FAIL prefix_code got %h want 74", code); end
    checks++; if ({extended, release_flag} !== 2'b11) begin errors++; $display("FAIL prefix_flags got %b want 11", {extended, release_flag}); end
    pop_one();
  endtask

  task automatic test_parity();
    int p0;
    send_frame(8'hE0, 1'b1, 1'b1);
    p0 = perr_n;
    send_frame(8'hAA, 1'b0, 1'b1);
    checks++; if (perr_n - p0 !== 1) begin errors++; $display("FAIL parity_pulse got %0d want 1", perr_n - p0); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL parity_count got %0d want 0", count); end
    send_frame(8'h1C, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (code !== 8'h1C) begin errors++; $display("FAIL parity_next_code got %h want 1c", code); end
    checks++; if ({extended, release_flag} !== 2'b00) begin errors++; $display("FAIL parity_next_flags got %b want 00", {extended, release_flag}); end
    pop_one();
  endtask

  task automatic test_stop_err();
    int f0;
    f0 = ferr_n;
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL stop_ferr got %0d want 1", ferr_n - f0); end
    checks++; if (count !== 3'd0 || perr_n < 0) begin errors++; $display("FAIL stop_count got %0d want 0", count); end
  endtask

  task automatic test_timeout();
    int f0;
    f0 = ferr_n;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (9800) @(posedge clk);
    @(negedge clk);
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL timeout_early got %0d want 0", ferr_n - f0); end
    repeat (300) @(posedge clk);
    @(negedge clk);
    checks++; if (ferr_n - f0 !== 1) begin errors++; $display("FAIL timeout_pulse got %0d want 1", ferr_n - f0); end
    send_frame(8'h29, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL timeout_next_count got %0d want 1", count); end
    checks++; if (code !== 8'h29) begin errors++; $display("FAIL timeout_next_code got %h want 29", code); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] seq [5];
    int o0;
    seq[0] = 8'h15; seq[1] = 8'h1D; seq[2] = 8'h24; seq[3] = 8'h2D; seq[4] = 8'h2C;
    o0 = ovf_n;
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b1, 1'b1);
    checks++; if (ovf_n - o0 !== 0) begin errors++; $display("FAIL ovf_early got %0d want 0", ovf_n - o0); end
    send_frame(seq[4], 1'b1, 1'b1);
    checks++; if (ovf_n - o0 !== 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", ovf_n - o0); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (valid !== 1'b1 || code !== seq[i]) begin
        errors++; $display("FAIL ovf_pop%0d got %h/%b want %h/1", i, code, valid, seq[i]);
      end
      pop_one();
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", valid); end
  endtask

  task automatic test_reset_midframe();
    int p0, f0;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    @(negedge clk); rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    p0 = perr_n; f0 = ferr_n;
    send_frame(8'h1C, 1'b1, 1'b1);
    @(negedge clk);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rstmid_count got %0d want 1", count); end
    checks++; if (code !== 8'h1C) begin errors++; $display("FAIL rstmid_code got %h want 1c", code); end
    checks++; if (perr_n - p0 !== 0) begin errors++; $display("FAIL rstmid_perr got %0d want 0", perr_n - p0); end
    checks++; if (ferr_n - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr got %0d want 0", ferr_n - f0); end
    pop_one();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_basic();
    test_prefix();
    test_parity();
    test_stop_err();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
